regfile_dump_reader: RTL
========================

# regfile_dump_reader

Sequential reader that streams a contiguous window of architectural registers out of the RV32I register file through its third read port (RA2/RD2), one register per beat, over a valid/ready stream. It sits beside the core datapath and feeds the debug/trace path (UART dumper, test-bench scoreboard) without disturbing the read ports used by decode.

## Interface
- NREGS, 32, number of architectural registers
- AW, 5, register address width
- DW, 32, register data width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request pulse; sampled only in IDLE
- start_idx  in  AW  first register index of the window
- count  in  AW+1  number of registers to dump; 0 means NREGS
- abort  in  1  cancel an in-progress dump
- ra  out  AW  read address to register file port RA2
- rd  in  DW  combinational read data from port RD2 (x0 reads 0)
- out_valid  out  1  out_data/out_addr/out_last hold a beat
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready
- out_data  out  DW  register value
- out_addr  out  AW  index of the register in out_data
- out_last  out  1  final beat of the window
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- States: IDLE, LOAD, STREAM.
- IDLE: on start (and no abort): ptr <= start_idx, remain <= (count==0 ? NREGS : count), go LOAD.
- ra = ptr at all times; rd is combinational, so capture needs no wait state.
- Capture (in LOAD, or in STREAM on handshake with remain>0): out_data <= rd, out_addr <= ptr, out_last <= (remain==1), ptr <= ptr+1 (mod NREGS, wraps 31->0), remain <= remain-1, out_valid <= 1.
- LOAD -> STREAM after one capture.
- STREAM: handshake with remain>0 -> capture next (back-to-back, one beat per cycle). Handshake with remain==0 -> out_valid <= 0, done <= 1, go IDLE.
- No handshake: out_data/out_addr/out_last/out_valid held stable.
- Captured value is the one readable before the capture edge; a same-edge write-back to that register is not seen (old value dumped).
- abort (any state, highest priority): next edge -> IDLE, out_valid <= 0, done stays 0. abort concurrent with start in IDLE: start ignored.
- start while busy: ignored, no queuing.
- remain width AW+1 so count = NREGS is representable.

## Timing
- Reset values: state IDLE, ptr 0, ra 0, out_valid 0, out_data 0, out_addr 0, out_last 0, busy 0, done 0.
- start sampled at edge E0 -> LOAD in cycle 1 (busy=1) -> out_valid=1 from cycle 2.
- With out_ready held 1: N beats in cycles 2..N+1; done=1 in cycle N+2, busy=0 in cycle N+2; new start accepted at end of cycle N+2.
- Backpressure: each cycle of out_ready=0 stretches the dump by one cycle; no beat dropped or duplicated.
- Reset asserted mid-dump: all outputs to reset values immediately (asynchronous), no done pulse.

## Structure
- Shared package: NREGS, AW, DW constants and the state enum (IDLE, LOAD, STREAM), reused by the UART dumper and bench scoreboard.
- Single flat module; no sub-module warranted.

## Test plan
- Preload x1..x31 = 0x1000_0000+i; start, start_idx=0, count=0, out_ready=1 -> 32 beats cycles 2..33, addr 0..31, data 0 then 0x1000_0001..0x1000_001F, out_last on addr 31, done in cycle 34.
- start_idx=30, count=4 -> addr 30,31,0,1 (wrap), data x30,x31,0,x1, out_last on addr 1.
- count=3, out_ready toggling 1,0,0,1,0,1 -> exactly 3 beats, each held stable while stalled, done one cycle after third acceptance.
- Write x5=0xDEAD_BEEF at the same edge x5 is captured -> beat shows old x5; rerun -> 0xDEAD_BEEF.
- abort in cycle 4 of a 32-register dump -> out_valid=0 next cycle, no done, busy=0; start re-issued in IDLE works; start pulsed while busy is ignored.
- rst asserted mid-STREAM -> out_valid, busy, ra, out_data return to 0 asynchronously.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// rtl/regfile_dump_reader_pkg.sv - shared constants and state codes for the register-file dump path
package regfile_dump_reader_pkg;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t LOAD   = 2'd1;
  localparam state_t STREAM = 2'd2;

  // Window length as loaded into the remain counter; zero selects the whole file.
  function automatic logic [AW:0] window_len(input logic [AW:0] count);
    return (count == '0) ? (AW+1)'(NREGS) : count;
  endfunction

  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx);
    return (idx == AW'(NREGS - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - streams a window of RV32I registers out through read port RA2/RD2
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_idx,
  input  logic [AW:0]   count,
  input  logic          abort,
  output logic [AW-1:0] ra,
  input  logic [DW-1:0] rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  state_t        state;
  logic [AW-1:0] ptr;
  logic [AW:0]   remain;
  logic          handshake;
  logic          capture;

  assign ra        = ptr;
  assign busy      = (state != IDLE);
  assign handshake = out_valid && out_ready;
  // rd is combinational off ptr, so a beat is captured the same cycle its address is presented.
  assign capture   = (state == LOAD) || ((state == STREAM) && handshake && (remain != '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      remain    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              ptr    <= start_idx;
              remain <= window_len(count);
              state  <= LOAD;
            end
          end
          LOAD:   state <= STREAM;
          STREAM: begin
            if (handshake && (remain == '0)) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase

        if (capture) begin
          out_data  <= rd;
          out_addr  <= ptr;
          out_last  <= (remain == (AW+1)'(1));
          ptr       <= next_idx(ptr);
          remain    <= remain - 1'b1;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
